// File: rtl/square_sched_if.sv
// rtl/square_sched_if.sv - request/result handshake bundle for square_sched
interface square_sched_if #(
  parameter int n = 3,
  parameter int R = 4
);
  localparam int IDW = $clog2(R);

  logic [R-1:0]   req_valid;
  logic [R*n-1:0] req_data;
  logic [R-1:0]   req_ready;
  logic           res_valid;
  logic [2*n-1:0] res_data;
  logic [IDW-1:0] res_id;
  logic           res_ready;
  logic           busy;

  modport master (
    output req_valid, req_data, res_ready,
    input  req_ready, res_valid, res_data, res_id, busy
  );

  modport slave (
    input  req_valid, req_data, res_ready,
    output req_ready, res_valid, res_data, res_id, busy
  );
endinterface

// File: rtl/square_sched.sv
// rtl/square_sched.sv - round-robin scheduler sharing one iterative shift-add squarer
// Optional SQ_SHORTCUT_EN: accepted operands 0 and 1 bypass CALC straight to DONE.
module square_sched #(
  parameter int n = 3,
  parameter int R = 4
) (
  input logic           clk,
  input logic           rst,
  square_sched_if.slave bus
);
  localparam int IDW = $clog2(R);
  localparam int CW  = (n > 1) ? $clog2(n) : 1;
  localparam int W2  = 2 * n;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;

  logic [IDW-1:0] rr_ptr;
  logic [n-1:0]   a;
  logic [IDW-1:0] id;
  logic [W2-1:0]  acc;
  logic [CW-1:0]  cnt;

  logic           res_valid_q;
  logic [W2-1:0]  res_data_q;
  logic [IDW-1:0] res_id_q;
  logic           busy_q;

  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] cand;
  logic [n-1:0]   grant_data;
  logic [W2-1:0]  acc_step;
  logic           last_step;
  logic           shortcut;

  // Search starts just past the last served requester and wraps.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 1; i <= R; i++) begin
      cand = IDW'((int'(rr_ptr) + i) % R);
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int k = 0; k < R; k++) begin
      if (grant_idx == IDW'(k)) grant_data = bus.req_data[k*n +: n];
    end
  end

  assign acc_step  = a[cnt] ? acc + (W2'(a) << cnt) : acc;
  assign last_step = (cnt == CW'(n - 1));

`ifdef SQ_SHORTCUT_EN
  assign shortcut = (grant_data[n-1:1] == '0);
`else
  assign shortcut = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.req_ready = '0;
    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          state_d = shortcut ? DONE : CALC;
          if (!rst) bus.req_ready = R'(1) << grant_idx;
        end
      end
      CALC:    if (last_step) state_d = DONE;
      DONE:    if (bus.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= IDW'(R - 1);
      a           <= '0;
      id          <= '0;
      acc         <= '0;
      cnt         <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      busy_q <= (state_d != IDLE);
      unique case (state_q)
        IDLE: begin
          if (grant_found) begin
            a      <= grant_data;
            id     <= grant_idx;
            rr_ptr <= grant_idx;
            acc    <= '0;
            cnt    <= '0;
            if (shortcut) begin
              res_valid_q <= 1'b1;
              res_data_q  <= W2'(grant_data);
              res_id_q    <= grant_idx;
            end
          end
        end
        CALC: begin
          acc <= acc_step;
          cnt <= cnt + 1'b1;
          if (last_step) begin
            res_valid_q <= 1'b1;
            res_data_q  <= acc_step;
            res_id_q    <= id;
          end
        end
        DONE:    if (bus.res_ready) res_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_id    = res_id_q;
  assign bus.busy      = busy_q;
endmodule
